// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundles the instruction-memory bus and the decode-side
// output handshake of the fetch stage.
//
// Signals:
//   imem_addr/imem_en/imem_wr  fetch -> memory   read address and strobe; imem_wr is always 0
//   imem_rdata                 memory -> fetch   instruction, returned in the same cycle
//   redirect_valid/redirect_pc downstream -> fetch  flush and reload the PC
//   out_valid/out_inst/out_pc/out_pc_plus2  fetch -> decode  FIFO head
//   out_ready                  decode -> fetch   accept the head
//   halted                     fetch -> env      a HALT was fetched and fetch is stopped
//
// Handshake: a head entry transfers on a rising edge where out_valid=1 and
// out_ready=1 and redirect_valid=0. While out_valid=1 and out_ready=0 the
// out_* values hold. out_ready has no effect while out_valid=0.
//
// Modports: master = fetch stage, slave = memory/decode side.
interface fetch_stage_if;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic        imem_wr;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_inst;
  logic [15:0] out_pc;
  logic [15:0] out_pc_plus2;
  logic        halted;

  modport master (
    output imem_addr, imem_en, imem_wr,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid, out_inst, out_pc, out_pc_plus2,
    input  out_ready,
    output halted
  );

  modport slave (
    input  imem_addr, imem_en, imem_wr,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid, out_inst, out_pc, out_pc_plus2,
    output out_ready,
    input  halted
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end. Holds the PC, reads the
// single-cycle instruction memory, and queues {instruction, PC} pairs in a
// small FIFO drained by decode. Redirects flush the FIFO and reload the PC;
// a fetched HALT stops fetching until the next redirect or reset.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  fetch_stage_if.master (memory bus, redirect, decode handshake, halted)
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          FIFO_DEPTH  = 2,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [15:0]   pc;
  logic          halted_q;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [15:0]   inst_mem [FIFO_DEPTH];
  logic [15:0]   pc_mem   [FIFO_DEPTH];

  logic head_valid;
  logic pop;
  logic not_full;
  logic fetch_ok;
  logic is_halt;

  assign head_valid = (count != '0);
  assign pop        = head_valid & bus.out_ready;
  assign not_full   = (count < CW'(FIFO_DEPTH));
  // A full FIFO may still accept a push when the head leaves on the same edge.
  assign fetch_ok   = ~rst & ~halted_q & ~bus.redirect_valid & (not_full | pop);
  assign is_halt    = (bus.imem_rdata[15:11] == HALT_OPCODE);

  assign bus.imem_addr    = pc & 16'hFFFE;
  assign bus.imem_en      = fetch_ok;
  assign bus.imem_wr      = 1'b0;
  assign bus.out_valid    = head_valid;
  // Storage is not reset, so outputs are forced to zero while the FIFO is empty.
  assign bus.out_inst     = head_valid ? inst_mem[rd_ptr] : 16'h0000;
  assign bus.out_pc       = head_valid ? pc_mem[rd_ptr]   : 16'h0000;
  assign bus.out_pc_plus2 = head_valid ? (pc_mem[rd_ptr] + 16'd2) : 16'h0000;
  assign bus.halted       = halted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC & 16'hFFFE;
      halted_q <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect_valid) begin
      // Redirect wins over everything: drop all entries, including the head.
      pc       <= bus.redirect_pc & 16'hFFFE;
      halted_q <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (fetch_ok) begin
        // pc advances past a HALT too, so it rests at HALT address + 2.
        pc     <= pc + 16'd2;
        wr_ptr <= wr_ptr + 1'b1;
        if (is_halt) begin
          halted_q <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({fetch_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fetch_ok) begin
      inst_mem[wr_ptr] <= bus.imem_rdata;
      pc_mem[wr_ptr]   <= pc & 16'hFFFE;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam int D = 2;
  localparam logic [15:0] RPC0 = 16'h0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if bus0 ();
  fetch_stage_if bus1 ();

  logic [15:0] mem [32768];

  assign bus0.imem_rdata = mem[bus0.imem_addr[15:1]];
  assign bus1.imem_rdata = mem[bus1.imem_addr[15:1]];
  assign bus1.out_ready      = 1'b1;
  assign bus1.redirect_valid = 1'b0;
  assign bus1.redirect_pc    = 16'h0000;

  fetch_stage #(.RESET_PC(RPC0), .FIFO_DEPTH(D), .HALT_OPCODE(5'b00000)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  fetch_stage #(.RESET_PC(16'hFFFE), .FIFO_DEPTH(2), .HALT_OPCODE(5'b00000)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];   // {inst, pc}, oldest first
  logic [15:0] m_pc;
  logic        m_halted;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of the reference model, evaluated after inputs settle.
  task automatic model_step();
    logic pop;
    logic fetch;
    logic [15:0] inst;
    if (rst) begin
      check("rst_out_valid", bus0.out_valid, 16'd0);
      check("rst_imem_en", bus0.imem_en, 16'd0);
      check("rst_halted", bus0.halted, 16'd0);
      check("rst_out_inst", bus0.out_inst, 16'd0);
      check("rst_out_pc", bus0.out_pc, 16'd0);
      check("rst_out_pc_plus2", bus0.out_pc_plus2, 16'd0);
      exp_q.delete();
      m_pc = RPC0;
      m_halted = 1'b0;
      return;
    end
    pop   = (exp_q.size() != 0) && bus0.out_ready && !bus0.redirect_valid;
    fetch = !m_halted && !bus0.redirect_valid && ((exp_q.size() < D) || pop);
    check("out_valid", bus0.out_valid, (exp_q.size() != 0) ? 16'd1 : 16'd0);
    check("imem_en", bus0.imem_en, fetch ? 16'd1 : 16'd0);
    check("imem_addr", bus0.imem_addr, m_pc);
    check("imem_wr", bus0.imem_wr, 16'd0);
    check("halted", bus0.halted, m_halted ? 16'd1 : 16'd0);
    if (bus0.redirect_valid) begin
      exp_q.delete();
      m_pc = bus0.redirect_pc & 16'hFFFE;
      m_halted = 1'b0;
    end else if (fetch) begin
      inst = mem[m_pc[15:1]];
      exp_q.push_back({inst, m_pc});
      if (inst[15:11] == 5'b00000) m_halted = 1'b1;
      m_pc = m_pc + 16'd2;
    end
  endtask

  // Monitor: pops the expected head whenever the DUT hands one to decode.
  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    if (!rst && !bus0.redirect_valid && bus0.out_valid && bus0.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got pc %h expected no entry at %0t", bus0.out_pc, $time);
      end else begin
        e = exp_q.pop_front();
        check("pop_inst", bus0.out_inst, e[31:16]);
        check("pop_pc", bus0.out_pc, e[15:0]);
        check("pop_pc_plus2", bus0.out_pc_plus2, e[15:0] + 16'd2);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic r, input logic ready, input logic redir, input logic [15:0] rpc);
    @(negedge clk);
    rst = r;
    bus0.out_ready = ready;
    bus0.redirect_valid = redir;
    bus0.redirect_pc = rpc;
    #1;
    model_step();
  endtask

  task automatic force_nonhalt(input int lo_addr, input int hi_addr);
    for (int a = lo_addr; a <= hi_addr; a += 2) mem[a >> 1] = mem[a >> 1] | 16'h0800;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus0.out_ready = 1'b0;
    bus0.redirect_valid = 1'b0;
    bus0.redirect_pc = 16'h0000;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    mem[3] = 16'h0000;          // HALT at 0x0006
    mem[32767] = 16'h1234;      // dut1 head at 0xFFFE
    force_nonhalt(16'h0040, 16'h0060);
    force_nonhalt(16'h0100, 16'h0120);
    force_nonhalt(16'h0200, 16'h0220);

    // Reset held, then released with decode stalled for 5 cycles.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    // dut1 (RESET_PC=0xFFFE, always ready): head 0xFFFE then 0x0000.
    cycle(0, 0, 0, 0);
    check("wrap_valid", bus1.out_valid, 16'd1);
    check("wrap_pc", bus1.out_pc, 16'hFFFE);
    check("wrap_pc_plus2", bus1.out_pc_plus2, 16'h0000);
    check("wrap_inst", bus1.out_inst, 16'h1234);
    cycle(0, 0, 0, 0);
    check("wrap_pc2", bus1.out_pc, 16'h0000);
    check("wrap_inst2", bus1.out_inst, 16'h1111);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    // Drain; fetch resumes at 0x0004 and reaches the HALT at 0x0006.
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0);

    // Redirect out of halt, fill FIFO, then redirect to an odd target.
    cycle(0, 0, 1, 16'h0100);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 16'h0041);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 16'($urandom));
    end

    // Asynchronous reset between edges while the FIFO holds entries.
    cycle(0, 0, 1, 16'h0200);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    #3;
    check("pre_async_valid", bus0.out_valid, 16'd1);
    rst = 1'b1;
    #1;
    check("async_out_valid", bus0.out_valid, 16'd0);
    check("async_imem_en", bus0.imem_en, 16'd0);
    check("async_halted", bus0.halted, 16'd0);
    exp_q.delete();
    m_pc = RPC0;
    m_halted = 1'b0;
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check("post_reset_pc", bus0.out_pc, RPC0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0);

    // ---------------- report ----------------
    @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end that sits directly upstream of the single-cycle instruction memory.
- Holds the PC and drives the memory's address/enable; memory read data returns combinationally in the same cycle.
- Each fetched instruction is captured together with its PC into a small FIFO, which the decode stage drains through a valid/ready handshake.
- Handles branch/jump redirects (flush) and stops fetching after a HALT instruction.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- FIFO_DEPTH, 2, fetch-buffer entries; power of two, range 2..8.
- HALT_OPCODE, 5'b00000, value of inst[15:11] that identifies HALT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  16  byte address to instruction memory; equals the PC, combinational.
- imem_en  out  1  instruction memory enable (read strobe).
- imem_wr  out  1  instruction memory write enable; constant 0.
- imem_rdata  in  16  instruction returned combinationally by memory.
- redirect_valid  in  1  taken branch/jump from downstream; flush and reload the PC.
- redirect_pc  in  16  redirect target byte address.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  16  head instruction.
- out_pc  out  16  head PC.
- out_pc_plus2  out  16  head PC + 2 (mod 2^16).
- halted  out  1  a HALT has been fetched; fetch is stopped.

Behaviour:
- Reset (async, while rst=1):
  - pc=RESET_PC, FIFO empty, count=0, halted=0.
  - out_valid=0; out_inst, out_pc and out_pc_plus2 all read 0.
  - imem_en=0.
- imem_addr = {pc[15:1],1'b0}. PC bit 0 is always 0.
- Redirect-target alignment: redirect_pc[0] is ignored (treated as 0).
- pop = out_valid & out_ready. The head advances on the clock edge.
- fetch_ok = ~rst & ~halted & ~redirect_valid & (count<FIFO_DEPTH | pop).
  - Push into a full FIFO is legal when a pop occurs in the same cycle.
- imem_en = fetch_ok.
- On a fetch edge:
  - Push {imem_rdata, pc} into the FIFO.
  - pc <= pc+2. Wrap-around: 16'hFFFE -> 16'h0000.
- HALT handling: if imem_rdata[15:11]==HALT_OPCODE on a fetch edge:
  - The HALT is still pushed.
  - halted <= 1.
  - pc holds at the HALT address + 2.
  - No further fetches occur until a redirect or reset.
- Redirect (redirect_valid=1 on an edge), highest priority:
  - FIFO cleared (count=0; all entries, including the head, discarded).
  - pop ignored.
  - pc <= redirect_pc & 16'hFFFE.
  - halted <= 0.
  - No push that cycle.
  - The first post-redirect instruction is fetched next cycle and is visible on out_* in the cycle after that edge.
- Latency, no stalls: fetch edge N -> out_valid=1 in cycle N+1. One instruction per cycle steady state.
- out_* reflect the head entry registered in the FIFO and are stable while out_valid=1 and out_ready=0.
- out_pc_plus2 = out_pc + 2, truncated to 16 bits.
- Simultaneous push and pop: count unchanged; order preserved.
- Empty FIFO: out_valid=0; out_ready is ignored.
- Full FIFO without pop: fetch_ok=0; pc and imem_en=0 hold.
- Reset mid-operation: all state is cleared immediately. Fetch resumes at RESET_PC on the first edge with rst=0.
- Registers: pc, FIFO storage/pointers/count, halted. No other state.

Test Plan:
- Reset, then memory words 0x1111, 0x2222, 0x3333 at 0x0000..0x0004, out_ready=1 -> out_inst sequence 0x1111/0x2222/0x3333 with out_pc 0x0000/0x0002/0x0004 on consecutive cycles; out_pc_plus2 = out_pc+2.
- out_ready=0 for 5 cycles from reset -> FIFO fills with 2 entries, imem_en drops to 0, pc stays 0x0004. out_ready=1 then drains 0x0000 and 0x0002 in order with no gap, and fetch resumes at 0x0004.
- Redirect to 0x0041 while FIFO holds 2 entries -> next cycle out_valid=0. Fetch at 0x0040 follows, so the following cycle shows out_pc=0x0040. Flushed entries never appear.
- HALT (0x0000) at 0x0006 -> halted=1 after that edge, imem_en=0, pc=0x0008, and the HALT is delivered with out_pc=0x0006. A later redirect to 0x0100 clears halted and fetch resumes.
- RESET_PC=16'hFFFE -> fetch out_pc 0xFFFE, then 0x0000; out_pc_plus2 for the head at 0xFFFE = 0x0000.
- Assert rst asynchronously between edges while out_valid=1 -> out_valid, imem_en and halted drop to 0 immediately; after release, the first out_pc=RESET_PC.
